// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared keypad definitions: responder states, key-code field
//               map and the idle column value.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } state_t;

    localparam int c_ROW_MSB = 3;
    localparam int c_ROW_LSB = 2;
    localparam int c_COL_MSB = 1;
    localparam int c_COL_LSB = 0;

    localparam logic [3:0] c_COLUMNA_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[c_ROW_MSB:c_ROW_LSB];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[c_COL_MSB:c_COL_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : bounce_gen
// Description : Contact-bounce waveform for one bounce phase: starts closed,
//               inverts every BOUNCE_TOGGLE cycles, ends open.
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_gen #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_TOGGLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic level,
    output logic phase_end
);

    localparam int c_CNT_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int c_TOG_W = $clog2(BOUNCE_TOGGLE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [c_TOG_W-1:0] c_TOG_LAST = c_TOG_W'(BOUNCE_TOGGLE - 1);

    logic               r_active;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TOG_W-1:0] r_tog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_level  <= 1'b0;
            r_cnt    <= '0;
            r_tog    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_level  <= 1'b1;
            r_cnt    <= '0;
            r_tog    <= '0;
        end else if (r_active) begin
            if (r_cnt == c_CNT_LAST) begin
                // Phase over: force open regardless of where the toggle stood
                r_active <= 1'b0;
                r_level  <= 1'b0;
                r_cnt    <= '0;
                r_tog    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (r_tog == c_TOG_LAST) begin
                    r_tog   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_tog <= r_tog + c_TOG_W'(1);
                end
            end
        end
    end

    assign level     = r_level;
    assign phase_end = r_active && (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_responder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_responder
// Description : Emulates a bouncing key press on a scanned 4x4 matrix keypad,
//               answering the row scan on the column lines.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_TOGGLE = 8,
    parameter int GAP_CYCLES    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fila,
    output logic [3:0]  columna,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done
);

    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_row;
    logic [1:0]         r_col;
    logic [15:0]        r_hold_len;
    logic [15:0]        r_hold_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [3:0]         r_columna;

    logic w_accept;
    logic w_hold_last;
    logic w_gap_last;
    logic w_bounce_start;
    logic w_bounce_level;
    logic w_bounce_end;
    logic w_contact;

    assign w_accept       = (r_state == IDLE) && cmd_valid;
    assign w_hold_last    = (r_state == HOLD) && (r_hold_cnt == r_hold_len - 16'd1);
    assign w_gap_last     = (r_state == GAP) && (r_gap_cnt == c_GAP_LAST);
    assign w_bounce_start = w_accept || w_hold_last;

    bounce_gen #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .BOUNCE_TOGGLE (BOUNCE_TOGGLE)
    ) u_bounce_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (w_bounce_start),
        .level     (w_bounce_level),
        .phase_end (w_bounce_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (cmd_valid)    w_state_nxt = BOUNCE_IN;
            BOUNCE_IN:  if (w_bounce_end) w_state_nxt = HOLD;
            HOLD:       if (w_hold_last)  w_state_nxt = BOUNCE_OUT;
            BOUNCE_OUT: if (w_bounce_end) w_state_nxt = GAP;
            GAP:        if (w_gap_last)   w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_row      <= 2'd0;
            r_col      <= 2'd0;
            r_hold_len <= 16'd0;
            r_hold_cnt <= 16'd0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_gap_last;
            if (w_accept) begin
                r_row      <= key_row(cmd_key);
                r_col      <= key_col(cmd_key);
                r_hold_len <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
            end
            r_hold_cnt <= ((r_state == HOLD) && !w_hold_last) ? r_hold_cnt + 16'd1 : 16'd0;
            r_gap_cnt  <= ((r_state == GAP) && !w_gap_last) ? r_gap_cnt + c_GAP_W'(1) : '0;
        end
    end

    assign w_contact = (r_state == HOLD) ||
                       (((r_state == BOUNCE_IN) || (r_state == BOUNCE_OUT)) && w_bounce_level);

    // Only the selected row is looked at, so several low rows never ghost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_columna <= c_COLUMNA_IDLE;
        end else begin
            r_columna <= c_COLUMNA_IDLE;
            if (w_contact && !fila[r_row]) begin
                r_columna[r_col] <= 1'b0;
            end
        end
    end

    assign columna   = r_columna;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_responder
// Description : Directed, table-driven bench for keypad_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_responder;

    localparam int B = 64;
    localparam int T = 8;
    localparam int G = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fila;
    logic [3:0]  columna;
    logic        cmd_valid;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic        cmd_ready;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keypad_responder #(
        .BOUNCE_CYCLES (B),
        .BOUNCE_TOGGLE (T),
        .GAP_CYCLES    (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fila      (fila),
        .columna   (columna),
        .cmd_valid (cmd_valid),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [3:0] fila;
        logic [3:0] exp_col;
    } idle_vec_t;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] hold;
        bit          all_rows;
        bit          poke;
        int          exp_busy;
        int          exp_low;
    } press_vec_t;

    idle_vec_t  iv[4];
    press_vec_t pv[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit contact_at(input int t, input int h);
        if (t < B)         return ((t / T) % 2) == 0;
        if (t < B + h)     return 1'b1;
        if (t < 2 * B + h) return (((t - B - h) / T) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] rot(input int t);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (t % 4));
    endfunction

    task automatic run_press(input press_vec_t v, input int idx);
        int         errs_col = 0;
        int         errs_ctl = 0;
        int         lows     = 0;
        int         h;
        logic [3:0] exp_col  = 4'b1111;
        logic [3:0] mask;
        logic [1:0] row;
        logic [1:0] col;
        row  = v.key[3:2];
        col  = v.key[1:0];
        h    = (v.hold == 16'd0) ? 1 : int'(v.hold);
        mask = 4'b1111;
        mask[col] = 1'b0;

        cmd_key   = v.key;
        cmd_hold  = v.hold;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Scribble over the command inputs; the press must not notice
        cmd_valid = 1'b0;
        cmd_key   = ~v.key;
        cmd_hold  = 16'd3;

        for (int t = 0; t <= v.exp_busy + 1; t++) begin
            if (columna !== exp_col) errs_col++;
            if (columna != 4'b1111) lows++;
            if (busy !== (t < v.exp_busy) || cmd_ready !== (t >= v.exp_busy) ||
                done !== (t == v.exp_busy)) errs_ctl++;
            if (v.poke && t == B + 5) begin
                cmd_valid = 1'b1;
                cmd_key   = 4'hF;
            end
            if (v.poke && t == B + 9) cmd_valid = 1'b0;
            fila    = v.all_rows ? 4'b0000 : rot(t);
            exp_col = (contact_at(t, h) && !fila[row]) ? mask : 4'b1111;
            @(posedge clk); #1;
        end
        check($sformatf("press%0d_columna_errs", idx), errs_col, 0);
        check($sformatf("press%0d_ctrl_errs", idx), errs_ctl, 0);
        if (v.exp_low >= 0) check($sformatf("press%0d_low_cycles", idx), lows, v.exp_low);
        fila = 4'b1111;
    endtask

    initial begin
        int errs;

        iv[0] = '{4'b1110, 4'b1111};
        iv[1] = '{4'b1101, 4'b1111};
        iv[2] = '{4'b1011, 4'b1111};
        iv[3] = '{4'b0111, 4'b1111};

        pv[0] = '{4'b0110, 16'd1000,  1'b0, 1'b0, 1384,  -1};
        pv[1] = '{4'b0000, 16'd0,     1'b1, 1'b0, 385,   65};
        pv[2] = '{4'b1111, 16'd5,     1'b1, 1'b0, 389,   69};
        pv[3] = '{4'b1001, 16'd40,    1'b0, 1'b1, 424,   -1};
        pv[4] = '{4'b0110, 16'hFFFF,  1'b1, 1'b0, 65919, 65599};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = 4'd0;
        cmd_hold  = 16'd0;
        fila      = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("reset_columna", columna, 4'b1111);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", cmd_ready, 1);
        rst = 1'b0;

        foreach (iv[i]) begin
            fila = iv[i].fila;
            @(posedge clk); #1;
            check($sformatf("idle%0d_columna", i), columna, iv[i].exp_col);
            check($sformatf("idle%0d_ready_busy", i), {cmd_ready, busy}, 2'b10);
        end
        fila = 4'b1111;

        foreach (pv[i]) run_press(pv[i], i);

        // Reset in the middle of HOLD, with cmd_valid raised during reset
        cmd_key   = 4'b0110;
        cmd_hold  = 16'd1000;
        cmd_valid = 1'b1;
        fila      = 4'b1101;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (B + 100) @(posedge clk);
        #1;
        check("midhold_columna", columna, 4'b1011);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_columna", columna, 4'b1111);
        check("rst_abort_busy", busy, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("valid_during_rst_ignored", busy, 0);
        check("ready_after_rst", cmd_ready, 1);
        errs = 0;
        for (int c = 0; c < 2000; c++) begin
            if (done !== 1'b0 || columna !== 4'b1111 || busy !== 1'b0) errs++;
            @(posedge clk); #1;
        end
        check("no_done_after_abort", errs, 0);
        fila = 4'b1111;
        run_press(pv[2], 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
